// File: rtl/acs_path_metric_8.sv
// acs_path_metric_8
//   Add-compare-select stage of an 8-state (K=4, rate 1/2) Viterbi decoder.
//   Each accepted 2-bit hard-decision symbol updates the eight path metrics
//   and produces one survivor decision bit per state.
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   frame_start         reload initial metrics (start state 0 is known)
//   in_valid, rx_sym    received symbol {c1,c0} and its qualifier
//   stateN_acc_error    registered metric of trellis state N-1
//   decision            1 = survivor into state s came from predecessor p1
//   out_valid           metrics/decision updated on the last edge
//   sym_count           symbols accepted since frame_start (wraps)
module acs_path_metric_8 #(
  parameter int          MW        = 7,
  parameter logic [3:0]  G0        = 4'b1111,
  parameter logic [3:0]  G1        = 4'b1011,
  parameter int          INIT_BIAS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          in_valid,
  input  logic [1:0]    rx_sym,
  output logic [MW-1:0] state1_acc_error,
  output logic [MW-1:0] state2_acc_error,
  output logic [MW-1:0] state3_acc_error,
  output logic [MW-1:0] state4_acc_error,
  output logic [MW-1:0] state5_acc_error,
  output logic [MW-1:0] state6_acc_error,
  output logic [MW-1:0] state7_acc_error,
  output logic [MW-1:0] state8_acc_error,
  output logic [7:0]    decision,
  output logic          out_valid,
  output logic [7:0]    sym_count
);

  localparam logic [MW:0]   HALF = (MW+1)'(1) << (MW-1);
  localparam logic [MW:0]   MAXV = {1'b0, {MW{1'b1}}};
  localparam logic [MW-1:0] BIAS = MW'(INIT_BIAS);

  logic [MW-1:0] pm_q    [8];
  logic [MW-1:0] pm_base [8];
  logic [MW-1:0] pm_next [8];
  logic [MW:0]   sel     [8];
  logic [7:0]    dec_next;

  function automatic logic [1:0] branch_metric(input logic [3:0] r, input logic [1:0] sym);
    logic [1:0] d;
    d = sym ^ {^(r & G1), ^(r & G0)};
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  always_comb begin
    logic [2:0]  nsb, p0, p1;
    logic [MW:0] cand0, cand1, v;
    logic        all_high;
    for (int unsigned i = 0; i < 8; i++)
      pm_base[i] = frame_start ? ((i == 0) ? '0 : BIAS) : pm_q[i];

    dec_next = '0;
    for (int unsigned ns = 0; ns < 8; ns++) begin
      nsb   = 3'(ns);
      p0    = {nsb[1:0], 1'b0};
      p1    = {nsb[1:0], 1'b1};
      // Sums are one bit wider than the metric so they cannot wrap.
      cand0 = {1'b0, pm_base[p0]} + (MW+1)'(branch_metric({nsb[2], p0}, rx_sym));
      cand1 = {1'b0, pm_base[p1]} + (MW+1)'(branch_metric({nsb[2], p1}, rx_sym));
      // Strict compare: ties resolve to p0, matching min_8 lowest-index-wins.
      dec_next[ns] = (cand1 < cand0);
      sel[ns]      = dec_next[ns] ? cand1 : cand0;
    end

    all_high = 1'b1;
    for (int unsigned i = 0; i < 8; i++)
      if (sel[i] < HALF) all_high = 1'b0;

    for (int unsigned i = 0; i < 8; i++) begin
      v          = all_high ? (sel[i] - HALF) : sel[i];
      pm_next[i] = (v > MAXV) ? {MW{1'b1}} : v[MW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++)
        pm_q[i] <= (i == 0) ? '0 : BIAS;
      decision  <= '0;
      out_valid <= 1'b0;
      sym_count <= '0;
    end else if (in_valid) begin
      for (int unsigned i = 0; i < 8; i++)
        pm_q[i] <= pm_next[i];
      decision  <= dec_next;
      out_valid <= 1'b1;
      sym_count <= frame_start ? 8'd1 : sym_count + 8'd1;
    end else begin
      out_valid <= 1'b0;
      if (frame_start) begin
        for (int unsigned i = 0; i < 8; i++)
          pm_q[i] <= (i == 0) ? '0 : BIAS;
        sym_count <= '0;
      end
    end
  end

  assign state1_acc_error = pm_q[0];
  assign state2_acc_error = pm_q[1];
  assign state3_acc_error = pm_q[2];
  assign state4_acc_error = pm_q[3];
  assign state5_acc_error = pm_q[4];
  assign state6_acc_error = pm_q[5];
  assign state7_acc_error = pm_q[6];
  assign state8_acc_error = pm_q[7];

endmodule

// File: tb/tb_acs_path_metric_8.sv
// Testbench for acs_path_metric_8: randomized stimulus against a forward-trellis
// reference model (enumerates every state/input transition with integers).
module tb_acs_path_metric_8;

  localparam int MW = 7;
  localparam int G0 = 15;  // 4'b1111
  localparam int G1 = 11;  // 4'b1011
  localparam int BIAS = 32;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    rx_sym = 2'b00;
  logic [MW-1:0] s1, s2, s3, s4, s5, s6, s7, s8;
  logic [7:0]    decision;
  logic          out_valid;
  logic [7:0]    sym_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  int        mdl_pm [8];
  bit [7:0]  mdl_dec;
  bit        mdl_ov;
  int        mdl_cnt;

  acs_path_metric_8 #(.MW(MW), .G0(4'b1111), .G1(4'b1011), .INIT_BIAS(BIAS)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
    .rx_sym(rx_sym),
    .state1_acc_error(s1), .state2_acc_error(s2), .state3_acc_error(s3),
    .state4_acc_error(s4), .state5_acc_error(s5), .state6_acc_error(s6),
    .state7_acc_error(s7), .state8_acc_error(s8),
    .decision(decision), .out_valid(out_valid), .sym_count(sym_count)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [8*MW-1:0] dut_vec();
    return {s8, s7, s6, s5, s4, s3, s2, s1};
  endfunction

  function automatic logic [8*MW-1:0] mdl_vec();
    logic [8*MW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*MW +: MW] = MW'(mdl_pm[i]);
    return v;
  endfunction

  function automatic int dut_metric(int idx);
    logic [8*MW-1:0] v;
    v = dut_vec();
    return int'(v[idx*MW +: MW]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mdl_pm[i] = (i == 0) ? 0 : BIAS;
    mdl_dec = '0; mdl_ov = 1'b0; mdl_cnt = 0;
  endfunction

  // Forward view of the trellis: every state s with input u goes to u*4 + s/2.
  function automatic void model_step(bit fs, bit v, bit [1:0] sym);
    int base [8];
    int best [8];
    int mn, reg4, c0, c1, ns, cand;
    if (v) begin
      for (int i = 0; i < 8; i++) begin
        base[i] = fs ? ((i == 0) ? 0 : BIAS) : mdl_pm[i];
        best[i] = 1000000;
      end
      for (int s = 0; s < 8; s++)
        for (int u = 0; u < 2; u++) begin
          ns   = u * 4 + s / 2;
          reg4 = u * 8 + s;
          c0   = $countones(reg4 & G0) % 2;
          c1   = $countones(reg4 & G1) % 2;
          cand = base[s] + ((c0 != int'(sym[0])) ? 1 : 0) + ((c1 != int'(sym[1])) ? 1 : 0);
          if (cand < best[ns]) begin
            best[ns] = cand;
            mdl_dec[ns] = bit'(s % 2);
          end
        end
      mn = best[0];
      for (int i = 1; i < 8; i++) if (best[i] < mn) mn = best[i];
      for (int i = 0; i < 8; i++) begin
        if (mn >= 64) best[i] -= 64;
        mdl_pm[i] = (best[i] > 127) ? 127 : best[i];
      end
      mdl_ov  = 1'b1;
      mdl_cnt = fs ? 1 : (mdl_cnt + 1) % 256;
    end else begin
      mdl_ov = 1'b0;
      if (fs) begin
        for (int i = 0; i < 8; i++) mdl_pm[i] = (i == 0) ? 0 : BIAS;
        mdl_cnt = 0;
      end
    end
  endfunction

  // Drive one cycle and advance the model; outputs sampled 1 ns after the edge.
  task automatic apply(input bit fs, input bit v, input bit [1:0] sym);
    @(negedge clk);
    frame_start = fs; in_valid = v; rx_sym = sym;
    @(posedge clk);
    #1;
    model_step(fs, v, sym);
    frame_start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    total_cnt++;
    if (dut_vec() !== mdl_vec()) $display("FAIL reset_metrics: got %h want %h", dut_vec(), mdl_vec());
    else pass_cnt++;
    total_cnt++;
    if ({decision, out_valid, sym_count} !== 17'd0)
      $display("FAIL reset_ctrl: dec=%h ov=%b cnt=%0d want 0", decision, out_valid, sym_count);
    else pass_cnt++;
    #3; rst_n = 1'b1;
    clk_en = 1'b1;
  endtask

  task automatic test_first_symbol();
    apply(1'b0, 1'b1, 2'b00);
    total_cnt++;
    if (s1 !== 7'd0 || s5 !== 7'd2 || decision[0] !== 1'b0 || decision[4] !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL first_sym: s1=%0d s5=%0d dec=%b ov=%b want s1=0 s5=2 dec[0]=dec[4]=0 ov=1",
               s1, s5, decision, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (dut_vec() !== mdl_vec() || decision !== mdl_dec || sym_count !== 8'(mdl_cnt))
      $display("FAIL first_sym_model: pm=%h dec=%h cnt=%0d want pm=%h dec=%h cnt=%0d",
               dut_vec(), decision, sym_count, mdl_vec(), mdl_dec, mdl_cnt);
    else pass_cnt++;
    apply(1'b0, 1'b0, 2'b00);
    total_cnt++;
    if (out_valid !== 1'b0 || dut_vec() !== mdl_vec())
      $display("FAIL first_sym_pulse: ov=%b want 0, pm=%h want %h", out_valid, dut_vec(), mdl_vec());
    else pass_cnt++;
  endtask

  task automatic test_noiseless();
    int st, u, r, mi, errs;
    bit [1:0] sym;
    st = 0; errs = 0;
    for (int k = 0; k < 64; k++) begin
      u   = int'($urandom_range(0, 1));
      r   = u * 8 + st;
      sym = 2'(($countones(r & G1) % 2) * 2 + ($countones(r & G0) % 2));
      st  = u * 4 + st / 2;
      apply(k == 0, 1'b1, sym);
      mi = 0;
      for (int i = 1; i < 8; i++) if (dut_metric(i) < dut_metric(mi)) mi = i;
      total_cnt++;
      if (mi !== st || dut_metric(mi) !== 0 || dut_vec() !== mdl_vec() || decision !== mdl_dec) begin
        $display("FAIL noiseless step %0d: argmin=%0d metric=%0d pm=%h want argmin=%0d metric=0 pm=%h",
                 k, mi, dut_metric(mi), dut_vec(), st, mdl_vec());
        errs++;
      end else pass_cnt++;
    end
    total_cnt++;
    if (sym_count !== 8'd64) $display("FAIL noiseless_count: got %0d want 64", sym_count);
    else pass_cnt++;
  endtask

  task automatic test_noise();
    int mn, mx;
    bit wrapped;
    bit [1:0] sym;
    wrapped = 1'b0;
    for (int k = 0; k < 300; k++) begin
      sym = 2'($urandom_range(0, 3));
      apply(1'b0, 1'b1, sym);
      mn = 1000; mx = 0;
      for (int i = 0; i < 8; i++) begin
        if (dut_metric(i) < mn) mn = dut_metric(i);
        if (dut_metric(i) > mx) mx = dut_metric(i);
      end
      total_cnt++;
      if (dut_vec() !== mdl_vec() || decision !== mdl_dec || sym_count !== 8'(mdl_cnt)
          || out_valid !== 1'b1 || mn >= 64 || mx > 127)
        $display("FAIL noise step %0d: pm=%h dec=%h cnt=%0d min=%0d want pm=%h dec=%h cnt=%0d min<64",
                 k, dut_vec(), decision, sym_count, mn, mdl_vec(), mdl_dec, mdl_cnt);
      else pass_cnt++;
      if (mdl_cnt == 0 && !wrapped) begin
        wrapped = 1'b1;
        total_cnt++;
        if (sym_count !== 8'd0) $display("FAIL count_wrap: got %0d want 0", sym_count);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_frame_start();
    apply(1'b1, 1'b1, 2'b11);
    total_cnt++;
    if (s1 !== 7'd2 || s5 !== 7'd0 || sym_count !== 8'd1 || out_valid !== 1'b1 || dut_vec() !== mdl_vec())
      $display("FAIL fs_valid: s1=%0d s5=%0d cnt=%0d ov=%b want s1=2 s5=0 cnt=1 ov=1",
               s1, s5, sym_count, out_valid);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) apply(1'b0, 1'b1, 2'($urandom_range(0, 3)));
    apply(1'b1, 1'b0, 2'b00);
    total_cnt++;
    if (dut_vec() !== mdl_vec() || sym_count !== 8'd0 || out_valid !== 1'b0)
      $display("FAIL fs_reload: pm=%h cnt=%0d ov=%b want pm=%h cnt=0 ov=0",
               dut_vec(), sym_count, out_valid, mdl_vec());
    else pass_cnt++;
  endtask

  task automatic test_gaps_and_reset();
    int gap;
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b1, 2'($urandom_range(0, 3)));
      gap = int'($urandom_range(1, 3));
      for (int g = 0; g < gap; g++) begin
        apply(1'b0, 1'b0, 2'($urandom_range(0, 3)));
        total_cnt++;
        if (dut_vec() !== mdl_vec() || decision !== mdl_dec || sym_count !== 8'(mdl_cnt) || out_valid !== 1'b0)
          $display("FAIL gap_hold: pm=%h dec=%h cnt=%0d ov=%b want pm=%h dec=%h cnt=%0d ov=0",
                   dut_vec(), decision, sym_count, out_valid, mdl_vec(), mdl_dec, mdl_cnt);
        else pass_cnt++;
      end
    end
    apply(1'b0, 1'b1, 2'b01);
    // Pulse reset between edges: no clock edge occurs before the check.
    rst_n = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if (dut_vec() !== mdl_vec() || decision !== 8'd0 || out_valid !== 1'b0 || sym_count !== 8'd0)
      $display("FAIL async_reset: pm=%h dec=%h ov=%b cnt=%0d want pm=%h dec=0 ov=0 cnt=0",
               dut_vec(), decision, out_valid, sym_count, mdl_vec());
    else pass_cnt++;
    #1; rst_n = 1'b1;
    apply(1'b0, 1'b1, 2'b00);
    total_cnt++;
    if (s1 !== 7'd0 || s5 !== 7'd2 || decision !== mdl_dec || dut_vec() !== mdl_vec() || sym_count !== 8'd1)
      $display("FAIL post_reset_sym: s1=%0d s5=%0d cnt=%0d want s1=0 s5=2 cnt=1", s1, s5, sym_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_symbol();
    test_noiseless();
    test_noise();
    test_frame_start();
    test_gaps_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
